// File: rtl/fi_pkg.sv
// Shared types for the fault-injectable register pipeline: fault modes,
// controller states and mode encodings.
package fi_pkg;

  localparam logic [1:0] MODE_NONE = 2'd0;
  localparam logic [1:0] MODE_FLIP = 2'd1;
  localparam logic [1:0] MODE_SA0  = 2'd2;
  localparam logic [1:0] MODE_SA1  = 2'd3;

  typedef enum logic [1:0] {
    FI_NONE = MODE_NONE,
    FI_FLIP = MODE_FLIP,
    FI_SA0  = MODE_SA0,
    FI_SA1  = MODE_SA1
  } fi_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_WAIT_VALID,
    ST_STUCK,
    ST_DONE
  } fi_state_e;

endpackage

// File: rtl/fi_stage.sv
// One WIDTH-bit valid/data pipeline register with a one-shot flip and a
// continuous stuck-at force on its visible output.
module fi_stage
  import fi_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  input  logic             flip_en,
  input  logic             force_en,
  input  logic             force_hi,
  input  logic [WIDTH-1:0] mask,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data
);

  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] flipped;

  // The flip is visible in its own cycle so a word leaving now carries it.
  assign flipped = flip_en ? (data_r ^ mask) : data_r;

  always_comb begin
    q_data = flipped;
    if (force_en) q_data = force_hi ? (data_r | mask) : (data_r & ~mask);
  end

  // Forced values are never stored here, so clearing the fault restores data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
      data_r  <= '0;
    end else if (load) begin
      q_valid <= d_valid;
      data_r  <= d_data;
    end else begin
      data_r  <= flipped;
    end
  end

endmodule

// File: rtl/fi_pipe_reg.sv
// DEPTH-stage valid/ready register pipeline with one central fault-injection
// controller. Define FI_PARITY_EN to carry a clean parity bit and flag faults.
//
// state      | meaning
// IDLE       | no fault scheduled
// ARMED      | counting down the trigger delay
// WAIT_VALID | delay expired, waiting for a valid word at the target stage
// STUCK      | stuck-at force held on the target stage until inj_clear
// DONE       | single flip applied, back to IDLE next cycle
module fi_pipe_reg
  import fi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int DLY_W = 8,
  parameter int CNT_W = 8,
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             inj_arm,
  input  logic [1:0]       inj_mode,
  input  logic [SW-1:0]    inj_stage,
  input  logic [WIDTH-1:0] inj_mask,
  input  logic [DLY_W-1:0] inj_delay,
  input  logic             inj_clear,
  output logic             inj_busy,
  output logic             inj_fired,
`ifdef FI_PARITY_EN
  output logic             out_parity_err,
`endif
  output logic [CNT_W-1:0] inj_count
);

  localparam logic [SW:0] DEPTH_C = (SW+1)'(DEPTH);

  fi_state_e        state_q;
  fi_mode_e         mode_q;
  logic [SW-1:0]    tgt_q;
  logic [WIDTH-1:0] mask_q;
  logic [DLY_W-1:0] cnt_q;
  logic             fired_q;
  logic [CNT_W-1:0] count_q;

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] q_data [DEPTH];
  logic             stage_ok, tgt_valid, fire, fire_flip, force_act;

  assign stage_ok  = {1'b0, inj_stage} < DEPTH_C;
  assign tgt_valid = v[tgt_q];
  // inj_clear wins over a fire in the same cycle.
  assign fire      = (state_q == ST_WAIT_VALID) && tgt_valid && !inj_clear;
  assign fire_flip = fire && (mode_q == FI_FLIP);
  assign force_act = (mode_q != FI_FLIP) && ((state_q == ST_STUCK) || fire);

  // A stage loads when empty or when its word moves on; ready ripples back.
  always_comb begin
    logic nxt;
    load = '0;
    nxt  = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      load[k] = !v[k] || nxt;
      nxt     = load[k];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             d_valid;
    logic [WIDTH-1:0] d_data;
    logic             hit;

    if (k == 0) begin : g_head
      assign d_valid = in_valid;
      assign d_data  = in_data;
    end else begin : g_body
      assign d_valid = v[k-1];
      assign d_data  = q_data[k-1];
    end

    assign hit = (tgt_q == SW'(k));

    fi_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (load[k]),
      .d_valid  (d_valid),
      .d_data   (d_data),
      .flip_en  (fire_flip && hit),
      .force_en (force_act && hit),
      .force_hi (mode_q == FI_SA1),
      .mask     (mask_q),
      .q_valid  (v[k]),
      .q_data   (q_data[k])
    );

`ifdef FI_PARITY_EN
    logic par_r;
    logic par_in;
    if (k == 0) begin : g_par_head
      assign par_in = ^in_data;
    end else begin : g_par_body
      assign par_in = g_stage[k-1].par_r;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst)       par_r <= 1'b0;
      else if (load[k]) par_r <= par_in;
    end
`endif
  end

  assign in_ready  = load[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = q_data[DEPTH-1];
  assign inj_busy  = (state_q != ST_IDLE);
  assign inj_fired = fired_q;
  assign inj_count = count_q;

`ifdef FI_PARITY_EN
  assign out_parity_err = out_valid && ((^out_data) != g_stage[DEPTH-1].par_r);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= FI_NONE;
      tgt_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      fired_q <= 1'b0;
      count_q <= '0;
    end else begin
      fired_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (inj_arm && (inj_mode != MODE_NONE) && stage_ok) begin
            mode_q  <= fi_mode_e'(inj_mode);
            tgt_q   <= inj_stage;
            mask_q  <= inj_mask;
            cnt_q   <= inj_delay;
            state_q <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (inj_clear)         state_q <= ST_IDLE;
          else if (cnt_q == '0)  state_q <= ST_WAIT_VALID;
          else                   cnt_q   <= cnt_q - DLY_W'(1);
        end
        ST_WAIT_VALID: begin
          if (inj_clear) begin
            state_q <= ST_IDLE;
          end else if (tgt_valid) begin
            fired_q <= 1'b1;
            if (count_q != '1) count_q <= count_q + CNT_W'(1);
            state_q <= (mode_q == FI_FLIP) ? ST_DONE : ST_STUCK;
          end
        end
        ST_STUCK: begin
          if (inj_clear) state_q <= ST_IDLE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fi_pipe_reg.sv
// Directed bench for fi_pipe_reg: streaming, flip, stuck-at, stalls and reset.
`timescale 1ns/1ps
module tb_fi_pipe_reg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int DLY_W = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_data, inj_mask;
  logic             inj_arm, inj_clear, inj_busy, inj_fired;
  logic [1:0]       inj_mode, inj_stage;
  logic [DLY_W-1:0] inj_delay;
  logic [CNT_W-1:0] inj_count;
  logic             perr;

  always #5 clk = ~clk;

  fi_pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DLY_W(DLY_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .inj_arm   (inj_arm),
    .inj_mode  (inj_mode),
    .inj_stage (inj_stage),
    .inj_mask  (inj_mask),
    .inj_delay (inj_delay),
    .inj_clear (inj_clear),
    .inj_busy  (inj_busy),
    .inj_fired (inj_fired),
`ifdef FI_PARITY_EN
    .out_parity_err (perr),
`endif
    .inj_count (inj_count)
  );

`ifndef FI_PARITY_EN
  assign perr = 1'b0;
`endif

  int         n_chk = 0;
  int         n_pass = 0;
  int         n_fired = 0;
  logic [8:0] outq[$];
  logic [7:0] expq[$];
  bit         rand_ready = 0;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) outq.push_back({perr, out_data});
    if (!rst && inj_fired) n_fired++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [7:0] d);
    logic acc;
    int   t;
    acc = 1'b0;
    t   = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && t < 200) begin
      #1 acc = in_ready;
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    if (!acc) chk("push_accept", {31'd0, acc}, 1);
  endtask

  task automatic drain(input int n);
    int t;
    t = 0;
    while (outq.size() < n && t < 600) begin tick(1); t++; end
    chk("drain_cnt", outq.size(), n);
  endtask

  task automatic arm(input logic [1:0] m, input logic [1:0] s, input logic [7:0] k, input logic [7:0] d);
    inj_mode = m; inj_stage = s; inj_mask = k; inj_delay = d;
    inj_arm = 1'b1;
    tick(1);
    inj_arm = 1'b0;
  endtask

  task automatic pulse_clear();
    inj_clear = 1'b1;
    tick(1);
    inj_clear = 1'b0;
  endtask

  initial begin
    int f0, hits, zeros, bad;
    logic [8:0] w;

    rst = 1'b1; in_valid = 0; in_data = 0; out_ready = 1; inj_arm = 0;
    inj_mode = 0; inj_stage = 0; inj_mask = 0; inj_delay = 0; inj_clear = 0;
    tick(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", inj_busy, 0);
    chk("rst_fired", inj_fired, 0);
    chk("rst_count", inj_count, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    tick(1);

    // plain streaming and latency
    for (int i = 1; i <= 16; i++) begin
      push(8'(i));
      if (i == 3) chk("lat_early", out_valid, 0);
      if (i == 4) begin
        chk("lat_first_v", out_valid, 1);
        chk("lat_first_d", out_data, 8'h01);
      end
    end
    drain(16);
    bad = 0;
    foreach (outq[i]) if (outq[i][7:0] != 8'(i + 1)) bad++;
    chk("stream_order", bad, 0);
    chk("stream_count", inj_count, 0);

    // mode 0 arm is ignored
    arm(2'd0, 2'd1, 8'hFF, 8'd0);
    chk("mode0_idle", inj_busy, 0);

    // single flip at stage 2
    outq.delete();
    f0 = n_fired;
    arm(2'd1, 2'd2, 8'h80, 8'd3);
    chk("flip_busy", inj_busy, 1);
    for (int i = 0; i < 20; i++) push(8'h00);
    drain(20);
    hits = 0; zeros = 0;
    foreach (outq[i]) begin
      if (outq[i][7:0] == 8'h80) hits++;
      if (outq[i][7:0] == 8'h00) zeros++;
    end
    chk("flip_hits", hits, 1);
    chk("flip_zeros", zeros, 19);
    chk("flip_pulses", n_fired - f0, 1);
    chk("flip_count", inj_count, 1);
    chk("flip_idle", inj_busy, 0);

    // stuck-at-1 at stage 0
    outq.delete();
    f0 = n_fired;
    arm(2'd3, 2'd0, 8'h0F, 8'd0);
    tick(3);
    chk("sa1_wait_busy", inj_busy, 1);
    for (int i = 0; i < 8; i++) push(8'hA0);
    drain(8);
    chk("sa1_busy", inj_busy, 1);
    chk("sa1_pulses", n_fired - f0, 1);
    arm(2'd1, 2'd0, 8'hF0, 8'd0);
    for (int i = 0; i < 4; i++) push(8'hA0);
    drain(12);
    bad = 0;
    foreach (outq[i]) if (outq[i][7:0] != 8'hAF) bad++;
    chk("sa1_words", bad, 0);
    pulse_clear();
    chk("sa1_clear_idle", inj_busy, 0);
    outq.delete();
    for (int i = 0; i < 4; i++) push(8'hA0);
    drain(4);
    bad = 0;
    foreach (outq[i]) if (outq[i][7:0] != 8'hA0) bad++;
    chk("sa1_cleared", bad, 0);
    chk("sa1_count", inj_count, 2);

    // flip armed on an empty pipe, random output stalls
    outq.delete();
    expq.delete();
    arm(2'd1, 2'd1, 8'h55, 8'd2);
    tick(10);
    chk("empty_wait", inj_busy, 1);
    chk("empty_nofire", inj_count, 2);
    rand_ready = 1;
    for (int i = 0; i < 32; i++) begin
      push(8'(8'h10 + i));
      expq.push_back((i == 0) ? 8'(8'h10 ^ 8'h55) : 8'(8'h10 + i));
    end
    drain(32);
    rand_ready = 0;
    tick(1);
    out_ready = 1;
    bad = 0;
    foreach (expq[i]) if (i >= outq.size() || outq[i][7:0] != expq[i]) bad++;
    chk("stall_scoreboard", bad, 0);
    chk("stall_count", inj_count, 3);

`ifdef FI_PARITY_EN
    outq.delete();
    arm(2'd1, 2'd1, 8'h01, 8'd0);
    tick(3);
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    drain(8);
    hits = 0; w = 9'h0;
    foreach (outq[i]) if (outq[i][8]) begin hits++; w = outq[i]; end
    chk("par_odd_errs", hits, 1);
    chk("par_odd_word", w, 9'h111);
    outq.delete();
    arm(2'd1, 2'd1, 8'h03, 8'd0);
    tick(3);
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    drain(8);
    hits = 0;
    foreach (outq[i]) if (outq[i][8]) hits++;
    chk("par_even_errs", hits, 0);
    chk("par_even_word", outq[0], 9'h013);
`endif

    // reset while armed with words held in flight
    out_ready = 0;
    arm(2'd1, 2'd3, 8'hFF, 8'd200);
    for (int i = 0; i < 3; i++) push(8'h33);
    chk("pre_rst_busy", inj_busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", inj_busy, 0);
    chk("mid_rst_count", inj_count, 0);
    tick(2);
    rst = 1'b0;
    out_ready = 1;
    outq.delete();
    tick(1);
    for (int i = 0; i < 8; i++) push(8'(8'h61 + i));
    drain(8);
    bad = 0;
    foreach (outq[i]) if (outq[i][7:0] != 8'(8'h61 + i)) bad++;
    chk("post_rst_stream", bad, 0);
    chk("post_rst_count", inj_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
